// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO peripheral: LED register with toggle mode, debounced switch inputs,
// sticky rising-edge status and a level interrupt; unmapped addresses pass RAM data through.
module mmio_gpio #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int N_OUT      = 4,
  parameter int N_IN       = 5,
  parameter int DEB_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] dir,
  input  logic [DATA_W-1:0] D,
  input  logic [DATA_W-1:0] ReadData,
  output logic [DATA_W-1:0] ReadDataOut,
  input  logic [N_IN-1:0]   sw,
  output logic [N_OUT-1:0]  LED,
  output logic              irq
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_TC = CNT_W'(DEB_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LED_A  = ADDR_W'((2 ** ADDR_W) - 1);
  localparam logic [ADDR_W-1:0] IN_A   = ADDR_W'((2 ** ADDR_W) - 2);
  localparam logic [ADDR_W-1:0] EDGE_A = ADDR_W'((2 ** ADDR_W) - 3);
  localparam logic [ADDR_W-1:0] CTRL_A = ADDR_W'((2 ** ADDR_W) - 4);

  logic [1:0]      ctrl_q;
  logic [N_IN-1:0] sync1_q, sync2_q, stable_q, stable_nxt, edge_q, rise, clr;
  logic [CNT_W-1:0] cnt_q [N_IN];
  logic            wr_led, wr_edge, wr_ctrl;
  logic            unused_d;

  assign wr_led  = MemWrite && (dir == LED_A);
  assign wr_edge = MemWrite && (dir == EDGE_A);
  assign wr_ctrl = MemWrite && (dir == CTRL_A);
  assign unused_d = ^D;

  // A bit adopts the synchronised value once it has disagreed for DEB_CYCLES consecutive edges.
  always_comb begin
    stable_nxt = stable_q;
    for (int i = 0; i < N_IN; i++) begin
      if ((sync2_q[i] != stable_q[i]) && (cnt_q[i] == CNT_TC)) stable_nxt[i] = sync2_q[i];
    end
    rise = stable_nxt & ~stable_q;
    clr  = wr_edge ? D[N_IN-1:0] : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      edge_q   <= '0;
      for (int i = 0; i < N_IN; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q  <= sw;
      sync2_q  <= sync1_q;
      stable_q <= stable_nxt;
      // Clear first, then OR in new rises so a same-edge set survives the clear.
      edge_q   <= (edge_q & ~clr) | rise;
      for (int i = 0; i < N_IN; i++) begin
        if ((sync2_q[i] == stable_q[i]) || (cnt_q[i] == CNT_TC)) cnt_q[i] <= '0;
        else                                                  cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      LED    <= '0;
      ctrl_q <= '0;
    end else begin
      if (wr_led) LED <= ctrl_q[1] ? (LED ^ D[N_OUT-1:0]) : D[N_OUT-1:0];
      if (wr_ctrl) ctrl_q <= D[1:0];
    end
  end

  assign irq = ctrl_q[0] & (|edge_q);

  always_comb begin
    ReadDataOut = ReadData;
    if      (dir == LED_A)  ReadDataOut = DATA_W'(LED);
    else if (dir == IN_A)   ReadDataOut = DATA_W'(stable_q);
    else if (dir == EDGE_A) ReadDataOut = DATA_W'(edge_q);
    else if (dir == CTRL_A) ReadDataOut = DATA_W'(ctrl_q);
  end

endmodule

// File: tb/tb_mmio_gpio.sv
// Scoreboard bench for mmio_gpio: a behavioural model predicts LED, irq and read data
// each cycle; a negedge monitor pops and compares.
module tb_mmio_gpio;
  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [4:0]  dir = '0;
  logic [31:0] D = '0;
  logic [31:0] ReadData = '0;
  logic [31:0] ReadDataOut;
  logic [4:0]  sw = '0;
  logic [3:0]  LED;
  logic        irq;

  always #5 clk = ~clk;

  mmio_gpio #(.ADDR_W(5), .DATA_W(32), .N_OUT(4), .N_IN(5), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .dir(dir), .D(D),
    .ReadData(ReadData), .ReadDataOut(ReadDataOut), .sw(sw), .LED(LED), .irq(irq)
  );

  typedef struct {
    logic [3:0]  led;
    logic        irq;
    logic [31:0] rdo;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [3:0] m_led;
  logic [1:0] m_ctrl;
  logic [4:0] m_stable, m_edge;
  int         m_run[5];
  logic [4:0] m_swq[$];   // switch samples still travelling through the synchroniser

  function automatic void model_reset();
    m_led = '0; m_ctrl = '0; m_stable = '0; m_edge = '0;
    foreach (m_run[i]) m_run[i] = 0;
    m_swq.delete();
    m_swq.push_back(5'b0);
    m_swq.push_back(5'b0);
  endfunction

  function automatic void model_edge();
    logic [4:0] smp;
    logic [4:0] rise;
    logic [1:0] ctrl_old;
    smp = m_swq.pop_front();
    m_swq.push_back(sw);
    rise = '0;
    ctrl_old = m_ctrl;
    for (int i = 0; i < 5; i++) begin
      if (smp[i] != m_stable[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_stable[i] = smp[i];
          m_run[i] = 0;
          if (smp[i]) rise[i] = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    if (MemWrite) begin
      case (dir)
        5'd31: m_led = ctrl_old[1] ? (m_led ^ D[3:0]) : D[3:0];
        5'd29: m_edge = m_edge & ~D[4:0];
        5'd28: m_ctrl = D[1:0];
        default: ;
      endcase
    end
    m_edge = m_edge | rise;
  endfunction

  function automatic logic [31:0] model_read();
    case (dir)
      5'd31:   return {28'b0, m_led};
      5'd30:   return {27'b0, m_stable};
      5'd29:   return {27'b0, m_edge};
      5'd28:   return {30'b0, m_ctrl};
      default: return ReadData;
    endcase
  endfunction

  // One clock cycle: advance the model past the edge, then drive the next inputs.
  task automatic cyc(input logic r, input logic mw, input logic [4:0] a,
                     input logic [31:0] d, input logic [4:0] s, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (reset) model_reset();
    else       model_edge();
    reset = r;
    if (r) model_reset();
    MemWrite = mw; dir = a; D = d; ReadData = $urandom; sw = s;
    e.led = m_led;
    e.irq = m_ctrl[0] & (|m_edge);
    e.rdo = model_read();
    e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({e.tag, ".led"}, {28'b0, LED}, {28'b0, e.led});
      chk({e.tag, ".irq"}, {31'b0, irq}, {31'b0, e.irq});
      chk({e.tag, ".rdo"}, ReadDataOut, e.rdo);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] s_hold;
    int         hold;
    model_reset();
    cyc(1, 0, 5'd31, 0, 0, "rst");
    cyc(0, 0, 5'd31, 0, 0, "rst_rel");

    // LED direct write, then toggle mode
    cyc(0, 1, 5'd31, 32'h0000_000A, 0, "led_wr");
    cyc(0, 1, 5'd28, 32'h2, 0, "ctrl_tog");
    cyc(0, 1, 5'd31, 32'h3, 0, "led_tog");
    cyc(0, 0, 5'd31, 0, 0, "led_rd");
    cyc(0, 1, 5'd28, 32'h0, 0, "ctrl_clr");

    // Debounce latency and glitch rejection
    for (int k = 0; k < 8; k++) cyc(0, 0, 5'd30, 0, 5'b00101, "deb_in");
    for (int k = 0; k < 3; k++) cyc(0, 0, 5'd30, 0, 5'b00111, "deb_pulse");
    for (int k = 0; k < 8; k++) cyc(0, 0, 5'd30, 0, 5'b00101, "deb_after");

    // Edge status and interrupt
    for (int k = 0; k < 8; k++) cyc(0, 0, 5'd30, 0, 5'b00000, "to_zero");
    cyc(0, 1, 5'd29, 32'h1F, 0, "edge_clr_all");
    cyc(0, 1, 5'd28, 32'h1, 0, "ie_on");
    for (int k = 0; k < 7; k++) cyc(0, 0, 5'd29, 0, 5'b00001, "edge_rise");
    cyc(0, 1, 5'd29, 32'h1, 5'b00001, "edge_w1c");
    cyc(0, 0, 5'd29, 0, 5'b00001, "edge_after");

    // Clear on the very edge bit 2 becomes stable: set must win
    cyc(0, 0, 5'd29, 0, 5'b00101, "svc_start");
    for (int k = 0; k < 4; k++) cyc(0, 0, 5'd29, 0, 5'b00101, "svc_wait");
    cyc(0, 1, 5'd29, 32'h4, 5'b00101, "svc_clr");
    cyc(0, 0, 5'd29, 0, 5'b00101, "svc_chk");

    // RAM pass-through and unmapped writes
    cyc(0, 1, 5'd7, 32'hFFFF_FFFF, 5'b00101, "pass_wr");
    cyc(0, 0, 5'd7, 0, 5'b00101, "pass_rd");
    cyc(0, 0, 5'd31, 0, 5'b00101, "pass_led");
    cyc(0, 0, 5'd28, 0, 5'b00101, "pass_ctrl");
    cyc(0, 1, 5'd30, 32'hFFFF_FFFF, 5'b00101, "in_wr");
    cyc(0, 0, 5'd30, 0, 5'b00101, "in_rd");

    // Async reset mid-count, then recovery with an input already high
    cyc(0, 1, 5'd28, 32'h0, 5'b00000, "ar_ctrl");
    cyc(0, 1, 5'd31, 32'hF, 5'b00000, "ar_led");
    for (int k = 0; k < 8; k++) cyc(0, 0, 5'd30, 0, 5'b00000, "ar_zero");
    cyc(0, 1, 5'd29, 32'h1F, 5'b00011, "ar_clr");
    for (int k = 0; k < 8; k++) cyc(0, 0, 5'd29, 0, 5'b00011, "ar_set");
    cyc(0, 1, 5'd28, 32'h1, 5'b00001, "ar_ie");
    cyc(0, 0, 5'd29, 0, 5'b00001, "ar_mid");
    cyc(1, 0, 5'd31, 0, 5'b00001, "ar_assert");
    cyc(1, 0, 5'd29, 0, 5'b00001, "ar_hold");
    for (int k = 0; k < 8; k++) cyc(0, 0, 5'd30, 0, 5'b00001, "ar_release");
    cyc(0, 0, 5'd29, 0, 5'b00001, "ar_edge");

    // Randomised traffic
    s_hold = '0;
    hold = 0;
    for (int k = 0; k < 1500; k++) begin
      logic [4:0] a;
      if (hold == 0) begin
        s_hold = 5'($urandom);
        hold = int'($urandom_range(1, 9));
      end
      hold--;
      case ($urandom_range(0, 5))
        0: a = 5'd31;
        1: a = 5'd30;
        2: a = 5'd29;
        3: a = 5'd28;
        default: a = 5'($urandom);
      endcase
      cyc(($urandom_range(0, 199) == 0), 1'($urandom), a, $urandom, s_hold, "rand");
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mmio_gpio.md
MMIO_GPIO -- requirements
Module: mmio_gpio

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_W, 5, data-address width.
- DATA_W, 32, data-bus width.
- N_OUT, 4, LED output channels; 1..DATA_W.
- N_IN, 5, switch input channels; 1..DATA_W.
- DEB_CYCLES, 16, debounce stability count; at least 1.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state on rising edge.
- reset, in, 1, asynchronous, active-high reset.
- MemWrite, in, 1, store strobe from control unit.
- dir, in, ADDR_W, data address (ALUResult low bits).
- D, in, DATA_W, store data (register-file RD2).
- ReadData, in, DATA_W, data RAM read output.
- ReadDataOut, out, DATA_W, load data to the result mux.
- sw, in, N_IN, raw asynchronous switch inputs.
- LED, out, N_OUT, registered LED outputs.
- irq, out, 1, level interrupt request.

Function
REQ-003 The address map SHALL be as follows; all other addresses are RAM:
- LED_A = 2^ADDR_W-1: LED register, R/W.
- IN_A = 2^ADDR_W-2: debounced inputs, read-only.
- EDGE_A = 2^ADDR_W-3: rising-edge sticky status, read, write-1-to-clear.
- CTRL_A = 2^ADDR_W-4: bit0 IE, bit1 TOG, R/W.
REQ-004 ReadDataOut SHALL be combinational from dir: the mapped register zero-extended to DATA_W, else ReadData unchanged.
REQ-005 A write SHALL occur only on a rising edge with MemWrite=1 and dir matching a mapped address; unused D bits SHALL be ignored.
REQ-006 On a LED_A write with TOG=0, LED SHALL be set to D[N_OUT-1:0]; with TOG=1, LED SHALL be set to LED XOR D[N_OUT-1:0]. TOG is the value before the edge.
REQ-007 LED SHALL change exactly one edge after the write and never combinationally from D.
REQ-008 Each sw bit SHALL pass through a 2-flop synchroniser, giving the sync value.
REQ-009 Each bit SHALL have a debounce counter of width clog2(DEB_CYCLES+1):
- sync == stable: counter clears to 0.
- sync != stable and counter == DEB_CYCLES-1: stable takes sync, counter clears to 0.
- otherwise: counter increments.
REQ-010 A constant sw change SHALL appear in IN_A exactly 2+DEB_CYCLES edges after the first edge that samples it.
REQ-011 A pulse shorter than DEB_CYCLES cycles (after synchronisation) SHALL NOT change stable.
REQ-012 A 0->1 transition of stable bit i SHALL set EDGE bit i on the same edge that stable updates. A 1->0 transition SHALL set nothing.
REQ-013 An EDGE_A write SHALL clear each bit where D[i]=1. If set and clear occur on the same edge for a bit, set SHALL win.
REQ-014 irq SHALL equal IE AND (OR of EDGE bits), decoded from registers only, with no combinational path from MemWrite, dir or D.
REQ-015 Writes to IN_A SHALL have no effect. Reads SHALL have no side effects.
REQ-016 Counters SHALL never exceed DEB_CYCLES-1 and SHALL NOT wrap.

Reset
REQ-017 reset=1 SHALL immediately, without waiting for clk, force:
- LED, EDGE, CTRL, stable, sync flops and counters to 0;
- irq to 0.
REQ-018 Reset asserted mid-debounce SHALL discard the partial count. After release, an input already high SHALL be reported after the full 2+DEB_CYCLES edges and SHALL set its EDGE bit.
REQ-019 The first edge after reset deassertion SHALL behave as a normal edge; no write is lost or duplicated.

Verification (DEB_CYCLES=4 for bench)
REQ-020 LED write: MemWrite=1, dir=31, D=0x0000000A, TOG=0 -> LED=4'hA after 1 edge. Then CTRL=0x2 and D=0x3 at dir=31 -> LED=4'h9.
REQ-021 Debounce: sw 00000->00101, held -> IN_A reads 0x5 at edge 6 and 0x0 at edge 5. A 3-cycle pulse on sw[1] -> IN_A never changes.
REQ-022 Edge/irq: CTRL=0x1, sw[0] rises -> EDGE=0x1 and irq=1 on the same edge stable updates. Write D=0x1 to dir=29 -> EDGE=0, irq=0 next edge.
REQ-023 Set-vs-clear: clear write of EDGE bit 2 on the same edge stable[2] rises -> EDGE[2]=1, irq stays 1.
REQ-024 Pass-through: dir=7 with ReadData=0xDEADBEEF -> ReadDataOut=0xDEADBEEF. MemWrite=1 at dir=7 -> LED, CTRL and EDGE unchanged.
REQ-025 Async reset: assert reset between edges with LED=0xF, EDGE=0x3, counters mid-count -> all outputs 0 before the next edge. Release with sw=0x1 held -> IN_A=0x1 at edge 6 after release, EDGE[0]=1.
